// File: rtl/piso_tx_arbiter.sv
// piso_tx_arbiter: round-robin arbiter sharing one MSB-first PISO serializer among NREQ requesters.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_tx_arbiter #(
    parameter int NREQ = 4,
    parameter int WIDTH = 4,
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  serial_out,
    output logic                  frame,
    output logic [IW-1:0]         src_id,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ACCEPT, SHIFT, PARITY} state_t;
    state_t state, state_nxt;
    logic [IW-1:0] ptr, w, win, ptr_nxt;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] shift_reg, word;
    logic hit, last;
`ifdef PISO_PARITY_EN
    logic par;
`endif
    // first valid requester at or after the pointer, wrapping
    always_comb begin
        win = ptr;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[(int'(ptr) + k) % NREQ]) win = IW'((int'(ptr) + k) % NREQ);
    end
    assign word = req_data[int'(w)*WIDTH +: WIDTH];
    assign hit = req_valid[w];
    assign last = cnt == CW'(WIDTH - 1);
    assign ptr_nxt = (int'(w) == NREQ - 1) ? '0 : w + 1'b1;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = |req_valid ? ACCEPT : IDLE;
            ACCEPT:  state_nxt = hit ? SHIFT : IDLE;
`ifdef PISO_PARITY_EN
            SHIFT:   state_nxt = last ? PARITY : SHIFT;
`else
            SHIFT:   state_nxt = last ? IDLE : SHIFT;
`endif
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            w         <= '0;
            cnt       <= '0;
            src_id    <= '0;
            shift_reg <= '0;
`ifdef PISO_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && |req_valid) w <= win;
            if (state == ACCEPT && hit) begin
                shift_reg <= word;
                src_id    <= w;
                ptr       <= ptr_nxt;
                cnt       <= '0;
`ifdef PISO_PARITY_EN
                par       <= ^word;
`endif
            end
            if (state == SHIFT) begin
                shift_reg <= shift_reg << 1;
                cnt       <= cnt + 1'b1;
            end
        end
    end
    assign req_ready = (state == ACCEPT) ? NREQ'(1) << w : '0;
    assign busy = state != IDLE;
`ifdef PISO_PARITY_EN
    assign frame = state == SHIFT || state == PARITY;
    assign serial_out = (state == SHIFT) ? shift_reg[WIDTH-1] : (state == PARITY) & par;
`else
    assign frame = state == SHIFT;
    assign serial_out = (state == SHIFT) & shift_reg[WIDTH-1];
`endif
endmodule

// File: tb/tb_piso_tx_arbiter.sv
// tb_piso_tx_arbiter: randomized requesters checked against a transaction-level bit-queue model.
// Honours PISO_PARITY_EN the same way as the design.
module tb_piso_tx_arbiter;
    localparam int NREQ = 4;
    localparam int WIDTH = 4;
    localparam int IW = 2;
    logic clk, rst;
    logic [NREQ-1:0] req_valid, req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic serial_out, frame, busy;
    logic [IW-1:0] src_id;
    piso_tx_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .serial_out(serial_out), .frame(frame),
        .src_id(src_id), .busy(busy)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    int vectors = 0, miscompares = 0;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask
    logic [NREQ-1:0] v, drop;
    logic [WIDTH-1:0] d [NREQ];
    int phase, mw, mptr, msrc;
    bit bits[$];
    task automatic drive();
        req_valid = v;
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = d[i];
    endtask
    initial begin
        rst = 1'b1;
        v = '1;
        drop = '0;
        for (int i = 0; i < NREQ; i++) d[i] = WIDTH'($urandom);
        drive();
        phase = 0; mw = 0; mptr = 0; msrc = 0;
        repeat (2) @(posedge clk);
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (c < 2) begin
                rst = 1'b1;
                v = '1;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (drop[i]) v[i] = 1'b0;
                    else if (!v[i] && $urandom_range(2) == 0) begin
                        v[i] = 1'b1;
                        d[i] = WIDTH'($urandom);
                    end else if (v[i] && $urandom_range(15) == 0) v[i] = 1'b0;
                end
                rst = phase != 1 && $urandom_range(149) == 0;
            end
            drop = '0;
            drive();
            #1;
            check("req_ready", 32'(req_ready), (phase == 1) ? 32'(1) << mw : 0);
            check("frame", 32'(frame), 32'(phase == 2));
            check("serial_out", 32'(serial_out), (phase == 2) ? 32'(bits[0]) : 0);
            check("busy", 32'(busy), 32'(phase != 0));
            check("src_id", 32'(src_id), 32'(msrc));
            if (rst) begin
                phase = 0; mptr = 0; msrc = 0;
                bits.delete();
            end else if (phase == 0) begin
                if (|v) begin
                    for (int k = 0; k < NREQ; k++)
                        if (v[(mptr + k) % NREQ]) begin
                            mw = (mptr + k) % NREQ;
                            break;
                        end
                    phase = 1;
                end
            end else if (phase == 1) begin
                if (v[mw]) begin
                    for (int b = WIDTH - 1; b >= 0; b--) bits.push_back(d[mw][b]);
`ifdef PISO_PARITY_EN
                    bits.push_back(^d[mw]);
`endif
                    msrc = mw;
                    mptr = (mw + 1) % NREQ;
                    drop[mw] = 1'b1;
                    phase = 2;
                end else phase = 0;
            end else begin
                void'(bits.pop_front());
                if (bits.size() == 0) phase = 0;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
